// File: rtl/serial_demux_param.sv
// Serial-to-N-channel demultiplexer: decodes start/address/length/payload/parity
// frames from a clkEn-paced serial line and routes payload bits to one channel.
module serial_demux_param #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              SerIn,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [N_CH-1:0]   ch_out,
    output logic [N_CH-1:0]   ch_valid,
    output logic              SerOutValid,
    output logic              drop,
    output logic              Done,
    output logic              parity_err,
    output logic              busy,
    output logic [LEN_W-1:0]  rem_cnt
);

    localparam int unsigned ADDR_W  = $clog2(N_CH);
    localparam int unsigned CNT_MAX = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_PAR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                par_q, par_d;
    logic                perr_q, perr_d;
    logic [N_CH-1:0]     ch_out_q, ch_out_d;
    logic [N_CH-1:0]     ch_valid_q, ch_valid_d;
    logic                sov_q, sov_d;
    logic                drop_q, drop_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    // State and output registers; every register advances only on a clkEn step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ch_out_q   <= '0;
            ch_valid_q <= '0;
            sov_q      <= 1'b0;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else if (clkEn) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ch_out_q   <= ch_out_d;
            ch_valid_q <= ch_valid_d;
            sov_q      <= sov_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output values for one step
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ch_out_d   = '0;
        ch_valid_d = '0;
        sov_d      = 1'b0;
        drop_d     = 1'b0;
        done_d     = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!SerIn) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_ADDR: begin
                addr_d = ADDR_W'({addr_q, SerIn});
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LEN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LEN: begin
                len_d = LEN_W'({len_q, SerIn});
                if (cnt_q == CNT_W'(LEN_W - 1)) begin
                    cnt_d = '0;
                    rem_d = len_d;
                    if (len_d != '0) begin
                        state_d = S_DATA;
                    end else if (PARITY_EN != 0) begin
                        state_d = S_PAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                par_d = par_q ^ SerIn;
                rem_d = rem_q - LEN_W'(1);
                if (ch_mask[addr_q]) begin
                    ch_valid_d = N_CH'(1) << addr_q;
                    ch_out_d   = N_CH'(SerIn) << addr_q;
                end else begin
                    drop_d = 1'b1;
                end
                if (rem_q == LEN_W'(1)) begin
                    state_d = (PARITY_EN != 0) ? S_PAR : S_DONE;
                end
            end
            S_PAR: begin
                perr_d  = par_q ^ SerIn;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Done is raised by the step taken in DONE, so it follows the last payload bit
        done_d = (state_q == S_DONE);
        busy_d = (state_d != S_IDLE);
        sov_d  = |ch_valid_d;
    end

    assign ch_out      = ch_out_q;
    assign ch_valid    = ch_valid_q;
    assign SerOutValid = sov_q;
    assign drop        = drop_q;
    assign Done        = done_q;
    assign parity_err  = perr_q;
    assign busy        = busy_q;
    assign rem_cnt     = rem_q;

endmodule

// File: tb/tb_serial_demux_param.sv
// Bench for serial_demux_param: three instances (4ch/no parity, 4ch/parity, 8ch/LEN_W=3)
// driven by a table of directed frames, hand sequences and random frames, checked per clk
// against a frame-level reference model.
module tb_serial_demux_param;

    typedef struct packed {
        logic [7:0] ch_out;
        logic [7:0] ch_valid;
        logic       sov;
        logic       drop;
        logic       done;
        logic       perr;
        logic       busy;
        logic [3:0] rem;
    } obs_t;

    typedef struct {
        int          dut;
        int          addr;
        int          len;
        logic [15:0] payload;
        logic        pbit;
        logic [7:0]  mask;
        int          div;
        int          exp_valid;
        int          exp_drop;
        logic        exp_perr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    logic ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1;
    logic [3:0] m0 = 4'hf, m1 = 4'hf;
    logic [7:0] m2 = 8'hff;

    logic [3:0] d0_out, d0_val, d0_rem, d1_out, d1_val, d1_rem;
    logic [7:0] d2_out, d2_val;
    logic [2:0] d2_rem;
    logic d0_sov, d0_drop, d0_done, d0_perr, d0_busy;
    logic d1_sov, d1_drop, d1_done, d1_perr, d1_busy;
    logic d2_sov, d2_drop, d2_done, d2_perr, d2_busy;

    int n_vec = 0;
    int n_err = 0;
    int cnt_v, cnt_d;
    logic [2:0] model_perr = 3'b000;

    always #5 clk = ~clk;

    serial_demux_param #(.N_CH(4), .LEN_W(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .clkEn(clk_en), .SerIn(ser0), .ch_mask(m0),
        .ch_out(d0_out), .ch_valid(d0_val), .SerOutValid(d0_sov), .drop(d0_drop),
        .Done(d0_done), .parity_err(d0_perr), .busy(d0_busy), .rem_cnt(d0_rem));

    serial_demux_param #(.N_CH(4), .LEN_W(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .clkEn(clk_en), .SerIn(ser1), .ch_mask(m1),
        .ch_out(d1_out), .ch_valid(d1_val), .SerOutValid(d1_sov), .drop(d1_drop),
        .Done(d1_done), .parity_err(d1_perr), .busy(d1_busy), .rem_cnt(d1_rem));

    serial_demux_param #(.N_CH(8), .LEN_W(3), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst(rst), .clkEn(clk_en), .SerIn(ser2), .ch_mask(m2),
        .ch_out(d2_out), .ch_valid(d2_val), .SerOutValid(d2_sov), .drop(d2_drop),
        .Done(d2_done), .parity_err(d2_perr), .busy(d2_busy), .rem_cnt(d2_rem));

    function automatic obs_t get_obs(input int d);
        obs_t a;
        a = '0;
        case (d)
            0: begin
                a.ch_out = 8'(d0_out); a.ch_valid = 8'(d0_val); a.sov = d0_sov;
                a.drop = d0_drop; a.done = d0_done; a.perr = d0_perr;
                a.busy = d0_busy; a.rem = d0_rem;
            end
            1: begin
                a.ch_out = 8'(d1_out); a.ch_valid = 8'(d1_val); a.sov = d1_sov;
                a.drop = d1_drop; a.done = d1_done; a.perr = d1_perr;
                a.busy = d1_busy; a.rem = d1_rem;
            end
            default: begin
                a.ch_out = d2_out; a.ch_valid = d2_val; a.sov = d2_sov;
                a.drop = d2_drop; a.done = d2_done; a.perr = d2_perr;
                a.busy = d2_busy; a.rem = 4'(d2_rem);
            end
        endcase
        return a;
    endfunction

    task automatic check(input int d, input obs_t e, input string nm);
        obs_t a;
        a = get_obs(d);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got out=%h val=%h sov=%b drop=%b done=%b perr=%b busy=%b rem=%0d, expected out=%h val=%h sov=%b drop=%b done=%b perr=%b busy=%b rem=%0d",
                     nm, d, $time, a.ch_out, a.ch_valid, a.sov, a.drop, a.done, a.perr, a.busy, a.rem,
                     e.ch_out, e.ch_valid, e.sov, e.drop, e.done, e.perr, e.busy, e.rem);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Only the addressed instance sees a non-idle line
    task automatic set_ser(input int d, input logic b);
        ser0 = (d == 0) ? b : 1'b1;
        ser1 = (d == 1) ? b : 1'b1;
        ser2 = (d == 2) ? b : 1'b1;
    endtask

    task automatic set_mask(input int d, input logic [7:0] m);
        case (d)
            0: m0 = m[3:0];
            1: m1 = m[3:0];
            default: m2 = m;
        endcase
    endtask

    // One bit period: clkEn high for the first clk of div clks; outputs must hold for all of them
    task automatic step(input int d, input logic b, input int div, input obs_t e, input string nm);
        obs_t a;
        set_ser(d, b);
        for (int c = 0; c < div; c++) begin
            clk_en = (c == 0);
            @(posedge clk);
            #1;
            check(d, e, nm);
            if (c == 0) begin
                a = get_obs(d);
                if (a.sov) cnt_v++;
                if (a.drop) cnt_d++;
            end
        end
    endtask

    task automatic idle(input int d, input int div);
        obs_t e;
        e = '0;
        e.perr = model_perr[d];
        step(d, 1'b1, div, e, "idle");
    endtask

    // Reference model: walks the frame field by field and predicts the outputs after each step
    task automatic send_frame(input int d, input int addr, input int len, input logic [15:0] pl,
                              input logic pbit, input logic [7:0] mask, input int div,
                              input bit rnd_mask, input int abort_at, input logic done_bit);
        obs_t e;
        int aw, lw;
        bit pe;
        logic [7:0] av, lv, m;
        logic x;
        aw = (d == 2) ? 3 : 2;
        lw = (d == 2) ? 3 : 4;
        pe = (d == 1);
        av = 8'(addr);
        lv = 8'(len);
        m = mask;
        x = 1'b0;
        cnt_v = 0;
        cnt_d = 0;
        set_mask(d, m);
        model_perr[d] = 1'b0;
        e = '0;
        e.busy = 1'b1;
        step(d, 1'b0, div, e, "start");
        for (int i = aw - 1; i >= 0; i--) step(d, av[i], div, e, "addr");
        for (int i = lw - 1; i >= 0; i--) begin
            if (i == 0) e.rem = 4'(len);
            step(d, lv[i], div, e, "len");
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) return;
            if (rnd_mask) begin
                m = 8'($urandom);
                set_mask(d, m);
            end
            x = x ^ pl[i];
            e = '0;
            e.busy = 1'b1;
            e.rem = 4'(len - 1 - i);
            if (m[addr]) begin
                e.ch_valid[addr] = 1'b1;
                e.ch_out[addr] = pl[i];
                e.sov = 1'b1;
            end else begin
                e.drop = 1'b1;
            end
            step(d, pl[i], div, e, "data");
        end
        if (pe) begin
            model_perr[d] = x ^ pbit;
            e = '0;
            e.busy = 1'b1;
            e.perr = model_perr[d];
            step(d, pbit, div, e, "parity");
        end
        e = '0;
        e.done = 1'b1;
        e.perr = model_perr[d];
        step(d, done_bit, div, e, "done");
    endtask

    task automatic check_all_zero(input string nm);
        for (int d = 0; d < 3; d++) check(d, obs_t'(0), nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        obs_t a;
        int d, addr, len;

        tbl[0] = '{0, 2, 3, 16'b101,     1'b0, 8'hff, 1, 3, 0, 1'b0};
        tbl[1] = '{0, 1, 0, 16'b0,       1'b0, 8'hff, 1, 0, 0, 1'b0};
        tbl[2] = '{0, 1, 2, 16'b11,      1'b0, 8'h0d, 1, 0, 2, 1'b0};
        tbl[3] = '{1, 3, 3, 16'b011,     1'b0, 8'hff, 1, 3, 0, 1'b0};
        tbl[4] = '{1, 3, 3, 16'b011,     1'b1, 8'hff, 1, 3, 0, 1'b1};
        tbl[5] = '{0, 2, 3, 16'b101,     1'b0, 8'hff, 4, 3, 0, 1'b0};
        tbl[6] = '{2, 7, 7, 16'b1001101, 1'b0, 8'hff, 1, 7, 0, 1'b0};
        tbl[7] = '{1, 0, 0, 16'b0,       1'b1, 8'hff, 1, 0, 0, 1'b1};

        // Power-on reset
        #2 rst = 1'b1;
        #10;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset_release");

        // Directed table
        for (int v = 0; v < 8; v++) begin
            send_frame(tbl[v].dut, tbl[v].addr, tbl[v].len, tbl[v].payload, tbl[v].pbit,
                       tbl[v].mask, tbl[v].div, 1'b0, -1, 1'b1);
            check_int($sformatf("vec%0d_valid_steps", v), cnt_v, tbl[v].exp_valid);
            check_int($sformatf("vec%0d_drop_steps", v), cnt_d, tbl[v].exp_drop);
            a = get_obs(tbl[v].dut);
            check_int($sformatf("vec%0d_parity_err", v), int'(a.perr), int'(tbl[v].exp_perr));
            idle(tbl[v].dut, 1);
            idle(tbl[v].dut, 1);
        end

        // Reset in the middle of DATA abandons the frame; the next frame decodes
        send_frame(0, 2, 5, 16'b10111, 1'b0, 8'hff, 1, 1'b0, 2, 1'b1);
        rst = 1'b1;
        #2;
        check_all_zero("reset_mid_data");
        rst = 1'b0;
        model_perr = 3'b000;
        set_ser(0, 1'b1);
        idle(0, 1);
        send_frame(0, 3, 4, 16'b0110, 1'b0, 8'hff, 1, 1'b0, -1, 1'b1);
        check_int("after_reset_valid_steps", cnt_v, 4);

        // Back-to-back frames where the DONE step carries the only idle bit
        send_frame(2, 5, 2, 16'b10, 1'b0, 8'hff, 1, 1'b0, -1, 1'b1);
        check_int("b2b_first_valid", cnt_v, 2);
        send_frame(2, 6, 3, 16'b111, 1'b0, 8'hff, 1, 1'b0, -1, 1'b1);
        check_int("b2b_second_valid", cnt_v, 3);
        idle(2, 1);

        // DONE step ignores a low SerIn
        send_frame(0, 0, 1, 16'b1, 1'b0, 8'hff, 1, 1'b0, -1, 1'b0);
        idle(0, 1);

        // Random frames with per-bit random masks
        for (int r = 0; r < 60; r++) begin
            d = int'($urandom_range(0, 2));
            addr = int'($urandom_range(0, (d == 2) ? 7 : 3));
            len = int'($urandom_range(0, (d == 2) ? 7 : 15));
            send_frame(d, addr, len, 16'($urandom), 1'($urandom), 8'($urandom),
                       int'($urandom_range(1, 2)), 1'b1, -1, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle(d, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
